readout_integrator: RTL and testbench

//  Downstream consumer of the crossbar readout quantiser's per-sample digital codes.
//  - Sequences a frame of NUM_COLS columns and drives col_sel to the upstream column mux.
//  - Integrates 2**LOG2_SAMPLES samples per column, averages them and subtracts a frame offset.
//  - Clamps the result at zero and emits one result per column on a valid/ready stream.

---
 rtl/xbar_readout_pkg.sv | 21 ++
 rtl/readout_integrator_if.sv | 25 ++
 rtl/readout_integrator.sv | 135 +++++++++++++
 tb/tb_readout_integrator.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_readout_pkg.sv
// Shared types and helpers for the crossbar readout integrator.
package xbar_readout_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        EMIT = 2'd2
    } integ_state_t;

    // Widest sample/result width the clamped subtract handles.
    localparam int unsigned SAT_W = 32;

    // avg - off with negative results clamped to zero.
    function automatic logic [SAT_W-1:0] sat_sub0(input logic [SAT_W-1:0] avg,
                                                  input logic [SAT_W-1:0] off);
        logic signed [SAT_W:0] diff;
        diff     = $signed({1'b0, avg}) - $signed({1'b0, off});
        sat_sub0 = diff[SAT_W] ? '0 : diff[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/readout_integrator_if.sv
// Sample input stream and result output stream of the readout integrator.
interface readout_integrator_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned COL_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sample_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [COL_W-1:0] out_col;

    // Producer of samples / consumer of results.
    modport master (
        output in_valid, sample_data, out_ready,
        input  in_ready, out_valid, out_data, out_col
    );

    // The integrator itself.
    modport slave (
        input  in_valid, sample_data, out_ready,
        output in_ready, out_valid, out_data, out_col
    );
endinterface

// File: rtl/readout_integrator.sv
// Per-column sample integrator: averages 2**LOG2_SAMPLES samples per column,
// subtracts a frame offset (clamped at zero) and streams one result per column.
module readout_integrator
    import xbar_readout_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned NUM_COLS     = 8,
    parameter int unsigned LOG2_SAMPLES = 2,
    localparam int unsigned COL_W       = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     offset,
    output logic [COL_W-1:0]     col_sel,
    output logic                 busy,
    output logic                 done,
    readout_integrator_if.slave  bus
);

    localparam int unsigned ACC_W       = WIDTH + LOG2_SAMPLES;
    localparam int unsigned CNT_W       = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1;
    localparam int unsigned NUM_SAMPLES = 1 << LOG2_SAMPLES;

    integ_state_t     state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [COL_W-1:0] col_sel_q, col_sel_d;
    logic [WIDTH-1:0] offset_q, offset_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [COL_W-1:0] out_col_q, out_col_d;
    logic             done_q, done_d;

    logic [ACC_W-1:0] sum;
    logic [WIDTH-1:0] avg;
    logic [WIDTH-1:0] result;

    // Running sum including the current sample, its average and the clamped result.
    always_comb begin
        sum    = acc_q + ACC_W'(bus.sample_data);
        avg    = WIDTH'(sum >> LOG2_SAMPLES);
        result = WIDTH'(sat_sub0(SAT_W'(avg), SAT_W'(offset_q)));
    end

    // Next-state and datapath update; abort overrides everything else.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        col_sel_d  = col_sel_q;
        offset_d   = offset_q;
        out_data_d = out_data_q;
        out_col_d  = out_col_q;
        done_d     = 1'b0;

        if (abort) begin
            state_d   = IDLE;
            acc_d     = '0;
            cnt_d     = '0;
            col_sel_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        offset_d  = offset;
                        acc_d     = '0;
                        cnt_d     = '0;
                        col_sel_d = '0;
                        state_d   = ACC;
                    end
                end
                ACC: begin
                    if (bus.in_valid) begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(NUM_SAMPLES - 1)) begin
                            out_data_d = result;
                            out_col_d  = col_sel_q;
                            state_d    = EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        acc_d = '0;
                        cnt_d = '0;
                        if (col_sel_q < COL_W'(NUM_COLS - 1)) begin
                            col_sel_d = col_sel_q + COL_W'(1);
                            state_d   = ACC;
                        end else begin
                            col_sel_d = '0;
                            done_d    = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            col_sel_q  <= '0;
            offset_q   <= '0;
            out_data_q <= '0;
            out_col_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            col_sel_q  <= col_sel_d;
            offset_q   <= offset_d;
            out_data_q <= out_data_d;
            out_col_q  <= out_col_d;
            done_q     <= done_d;
        end
    end

    // Handshake flags decode straight from state; data outputs come from flops.
    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == EMIT);
    assign busy          = (state_q != IDLE);
    assign bus.out_data  = out_data_q;
    assign bus.out_col   = out_col_q;
    assign col_sel       = col_sel_q;
    assign done          = done_q;

endmodule

// File: tb/tb_readout_integrator.sv
// Scoreboard bench for readout_integrator (WIDTH=16, NUM_COLS=4, LOG2_SAMPLES=2).
module tb_readout_integrator;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned LOG2_S   = 2;
    localparam int unsigned COL_W    = 2;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [COL_W-1:0] col;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] offset = '0;
    logic [COL_W-1:0] col_sel;
    logic             busy;
    logic             done;

    readout_integrator_if #(.WIDTH(WIDTH), .COL_W(COL_W)) bus ();

    readout_integrator #(
        .WIDTH(WIDTH), .NUM_COLS(NUM_COLS), .LOG2_SAMPLES(LOG2_S)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .offset(offset),
        .col_sel(col_sel), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    // Count done pulses independently of the directed checks.
    always @(negedge clk) if (!reset && done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [WIDTH-1:0] off);
        start  = 1'b1;
        offset = off;
        tick();
        start  = 1'b0;
        offset = 16'hffff;
        check("start_busy", busy, 1);
        check("start_col", col_sel, 0);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_col", col_sel, 0);
        check("abort_ov", bus.out_valid, 0);
    endtask

    // Feed four samples of one column and push the model result.
    task automatic feed_col(input int col, input logic [WIDTH-1:0] s0, s1, s2, s3,
                            input int off, input bit inject_start);
        logic [WIDTH-1:0] s [4];
        int   sum;
        int   avg;
        exp_t e;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid    = 1'b1;
            bus.sample_data = s[i];
            start  = inject_start && (i == 1);
            offset = inject_start ? 16'd0 : 16'hffff;
            check("in_ready", bus.in_ready, 1);
            check("col_sel", col_sel, 32'(col));
            check("ov_low", bus.out_valid, 0);
            sum += int'(s[i]);
            tick();
        end
        bus.in_valid = 1'b0;
        start = 1'b0;
        avg = sum >> LOG2_S;
        e.data = (avg > off) ? WIDTH'(avg - off) : '0;
        e.col  = COL_W'(col);
        sb.push_back(e);
        check("latency_ov", bus.out_valid, 1);
        check("emit_in_ready", bus.in_ready, 0);
    endtask

    // Hold the result for 'hold' cycles, then accept it and check against the scoreboard.
    task automatic drain(input int hold, input bit last);
        exp_t e;
        logic [WIDTH-1:0] d0;
        logic [COL_W-1:0] c0, cs0;
        int   n;
        int   dc0;
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        bus.out_ready   = 1'b0;
        bus.in_valid    = 1'b1;
        bus.sample_data = 16'h1234;
        d0 = bus.out_data; c0 = bus.out_col; cs0 = col_sel;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_data", bus.out_data, d0);
            check("hold_col", bus.out_col, c0);
            check("hold_sel", col_sel, cs0);
            check("hold_ov", bus.out_valid, 1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("out_valid", bus.out_valid, 1);
        check("out_data", bus.out_data, e.data);
        check("out_col", bus.out_col, e.col);
        check("sel_match", col_sel, e.col);
        dc0 = done_cnt;
        tick();
        bus.out_ready = 1'b0;
        if (last) begin
            check("done_pulse", done, 1);
            check("last_busy", busy, 0);
            check("last_sel", col_sel, 0);
            tick();
            check("done_drop", done, 0);
            check("done_once", done_cnt - dc0, 1);
        end else begin
            check("mid_done", done, 0);
            check("mid_ov", bus.out_valid, 0);
            check("next_sel", col_sel, 32'(e.col) + 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int off;
        logic [WIDTH-1:0] r [16];
        bus.in_valid    = 1'b0;
        bus.sample_data = '0;
        bus.out_ready   = 1'b0;

        // Power-on reset.
        #22;
        check("rst_busy", busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_ov", bus.out_valid, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        tick();
        check("idle_in_ready", bus.in_ready, 0);

        // Average, latency and hold-off; then reset mid-frame.
        do_start(16'd0);
        feed_col(0, 16'd100, 16'd200, 16'd300, 16'd400, 0, 1'b0);
        drain(5, 1'b0);
        bus.in_valid = 1'b1; bus.sample_data = 16'd7;
        tick(); tick();
        bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_in_ready", bus.in_ready, 0);
        check("mrst_ov", bus.out_valid, 0);
        check("mrst_col", col_sel, 0);
        check("mrst_data", bus.out_data, 0);
        check("mrst_done", done, 0);
        #3 reset = 1'b0;
        tick();
        check("post_rst_busy", busy, 0);

        // Clamp at zero.
        do_start(16'd300);
        feed_col(0, 16'd100, 16'd100, 16'd100, 16'd100, 300, 1'b0);
        drain(0, 1'b0);
        do_abort();

        // Full-scale samples, no overflow.
        do_start(16'd50);
        feed_col(0, 16'hffff, 16'hffff, 16'hffff, 16'hffff, 50, 1'b0);
        drain(0, 1'b0);
        do_abort();

        // Full frame with an ignored start during column 1.
        off = int'($urandom_range(0, 2000));
        for (int i = 0; i < 16; i++) r[i] = WIDTH'($urandom_range(0, 65535));
        dc = done_cnt;
        do_start(WIDTH'(off));
        for (int c = 0; c < 4; c++) begin
            feed_col(c, r[4*c], r[4*c+1], r[4*c+2], r[4*c+3], off, c == 1);
            drain(0, c == 3);
        end
        check("frame_done_cnt", done_cnt - dc, 1);

        // Abort during column 2 accumulation.
        dc = done_cnt;
        do_start(16'd10);
        feed_col(0, 16'd40, 16'd40, 16'd40, 16'd40, 10, 1'b0);
        drain(0, 1'b0);
        feed_col(1, 16'd80, 16'd80, 16'd80, 16'd80, 10, 1'b0);
        drain(0, 1'b0);
        bus.in_valid = 1'b1; bus.sample_data = 16'd5;
        tick(); tick();
        bus.in_valid = 1'b0;
        do_abort();

        // Abort coincident with the final column's result handshake.
        do_start(16'd0);
        for (int c = 0; c < 3; c++) begin
            feed_col(c, 16'd8, 16'd8, 16'd8, 16'd8, 0, 1'b0);
            drain(0, 1'b0);
        end
        feed_col(3, 16'd9, 16'd9, 16'd9, 16'd9, 0, 1'b0);
        void'(sb.pop_front());
        bus.out_ready = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        bus.out_ready = 1'b0;
        check("abhs_busy", busy, 0);
        check("abhs_ov", bus.out_valid, 0);
        check("abhs_done", done, 0);
        tick();
        check("abhs_done2", done, 0);
        check("abort_no_done", done_cnt - dc, 0);

        // A fresh start after abort begins at column 0.
        do_start(16'd0);
        check("restart_in_ready", bus.in_ready, 1);
        do_abort();
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
